// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants, types and the read-credit helper for the FIFO stream reader.
package fifo_stream_reader_pkg;

    localparam int BRAM_RD_LATENCY = 1;
    localparam int SKID_DEPTH      = 2;
    localparam int OCC_WIDTH       = 2;

    typedef logic [OCC_WIDTH-1:0]       occ_t;
    typedef logic [BRAM_RD_LATENCY-1:0] pend_t;

    // A new read may issue only if, after this cycle's pop, its returning word still fits.
    function automatic logic has_credit(input occ_t occ, input logic pop);
        return ((occ - occ_t'(pop)) < occ_t'(SKID_DEPTH));
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port and output-stream signals of the reader, with reader/consumer views.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_re;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output fifo_re,
        output m_data,
        output m_valid,
        input  fifo_q,
        input  fifo_empty,
        input  m_ready
    );

    modport slave (
        input  fifo_re,
        input  m_data,
        input  m_valid,
        output fifo_q,
        output fifo_empty,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader_stream_buf2.sv
// Two-entry in-order output queue; entry0 is always the head presented downstream.
module stream_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output occ_t                  count_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    occ_t                  count_q, count_d;
    logic                  valid_q, valid_d;

    // Next-state queue update: simultaneous push and pop keeps the count and the order.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        if (clear_i) begin
            count_d = occ_t'(0);
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == occ_t'(0)) begin
                        entry0_d = push_data_i;
                    end else begin
                        entry1_d = push_data_i;
                    end
                    count_d = count_q + occ_t'(1);
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - occ_t'(1);
                end
                2'b11: begin
                    if (count_q == occ_t'(1)) begin
                        entry0_d = push_data_i;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_data_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != occ_t'(0));
    end

    // Queue storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0_q <= {DATA_WIDTH{1'b0}};
            entry1_q <= {DATA_WIDTH{1'b0}};
            count_q  <= occ_t'(0);
            valid_q  <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign head_data_o = entry0_q;
    assign count_o     = count_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream at one beat per cycle,
// with a flush mode that discards everything and a wrapping delivered-beat counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    r_clk,
    input  logic                    rst_n,
    fifo_stream_reader_if.master    bus,
    input  logic                    flush,
    output logic                    busy,
    output logic [COUNT_WIDTH-1:0]  rd_count
);

    pend_t                  pend_q, pend_d;
    logic                   pend_discard_q, pend_discard_d;
    logic [COUNT_WIDTH-1:0] rd_count_q, rd_count_d;

    occ_t                   buf_count_s;
    occ_t                   occ_s;
    logic                   buf_valid_s;
    logic [DATA_WIDTH-1:0]  head_data_s;
    logic                   in_flight_s;
    logic                   pop_s;
    logic                   accept_s;
    logic                   capture_s;
    logic                   fifo_re_s;

    assign in_flight_s = pend_q[BRAM_RD_LATENCY-1];
    assign pop_s       = buf_valid_s & bus.m_ready;
    assign accept_s    = pop_s & ~flush;
    assign occ_s       = buf_count_s + occ_t'(in_flight_s);
    // A word read during flush is tagged so it is still dropped after flush falls.
    assign capture_s   = in_flight_s & ~pend_discard_q & ~flush;
    assign fifo_re_s   = rst_n & ~bus.fifo_empty & (flush | has_credit(occ_s, pop_s));

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (r_clk),
        .rst_ni      (rst_n),
        .clear_i     (flush),
        .push_i      (capture_s),
        .push_data_i (bus.fifo_q),
        .pop_i       (accept_s),
        .head_data_o (head_data_s),
        .count_o     (buf_count_s),
        .valid_o     (buf_valid_s)
    );

    // Next state of the read-tracking flags and the beat counter.
    always_comb begin
        pend_d         = pend_t'(fifo_re_s);
        pend_discard_d = fifo_re_s & flush;
        if (accept_s) begin
            rd_count_d = rd_count_q + COUNT_WIDTH'(1);
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Read-tracking flags and beat counter registers.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q         <= pend_t'(0);
            pend_discard_q <= 1'b0;
            rd_count_q     <= {COUNT_WIDTH{1'b0}};
        end else begin
            pend_q         <= pend_d;
            pend_discard_q <= pend_discard_d;
            rd_count_q     <= rd_count_d;
        end
    end

    assign bus.fifo_re = fifo_re_s;
    assign bus.m_data  = head_data_s;
    assign bus.m_valid = buf_valid_s;
    assign busy        = in_flight_s | (buf_count_s != occ_t'(0));
    assign rd_count    = rd_count_q;

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side drain engine for the BRAM-backed `fifo`. It issues `re` pops against the FIFO's registered read port, where data appears one cycle after `re`. It buffers the returned words in a 2-entry output buffer and presents them on a valid/ready stream at full throughput (one beat per cycle).
It also provides a flush/drain mode that discards FIFO contents, and a delivered-beat counter for debug.

Parameters:
DATA_WIDTH, 8, width of FIFO word and stream data (1..16, matches the `fifo` instance).
COUNT_WIDTH, 16, width of the delivered-beat counter.

Ports:
r_clk  in  1  read-side clock, the same clock that drives the FIFO's r_clk.
rst_n  in  1  asynchronous, active-low reset.
fifo_re  out  1  pop strobe to the FIFO `re`.
fifo_q  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_re`.
fifo_empty  in  1  FIFO empty flag.
m_data  out  DATA_WIDTH  stream data.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from the consumer.
flush  in  1  synchronous discard/drain request, level-sensitive.
busy  out  1  high while any read is in flight or any word is buffered.
rd_count  out  COUNT_WIDTH  count of beats accepted (m_valid & m_ready), wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async assert, sync release): m_valid=0, fifo_re=0, busy=0, rd_count=0, buffer empty, pend=0, pend_discard=0, m_data=0.
- pend: registered copy of fifo_re (one read in flight). pend_discard: registered copy of (fifo_re & flush).
- pop = m_valid & m_ready.
- occ = buf_count + pend, ranging 0..2.
- fifo_re (combinational) = ~fifo_empty & (flush | (occ - pop < 2)).
  - fifo_re is never asserted while fifo_empty=1.
  - In steady state with m_ready=1, fifo_re stays high every cycle.
- Capture: when pend=1 and pend_discard=0, fifo_q is written into the buffer tail at that edge.
  - The credit rule guarantees buf_count + capture - pop <= 2, so the buffer never overflows. The bench asserts this.
- Latency: fifo_re high in cycle t gives the word on m_data with m_valid=1 in cycle t+2 (registered output, no bypass).
- The buffer is a 2-entry in-order queue.
  - m_data is the head; it is stable while m_valid & ~m_ready.
  - Simultaneous capture and pop in the same cycle is legal. The count is unchanged and order is preserved.
- flush=1:
  - buffer cleared and m_valid=0 from the next cycle;
  - in-flight capture dropped;
  - fifo_re = ~fifo_empty, so the FIFO is drained to empty;
  - rd_count is not incremented.
- A read issued in the last flush cycle is still discarded on the following cycle (pend_discard), even though flush has fallen.
- Normal operation resumes the cycle after flush falls.
- busy = pend | (buf_count != 0).
- rd_count increments by 1 on each pop and wraps at 2^COUNT_WIDTH.
- Reset mid-operation: the in-flight word and buffered words are lost. The FIFO pointers are not affected; this block does not reset the FIFO.
- fifo_empty rising while pend=1: the capture still occurs. No further fifo_re is issued.

Decomposition:
- Shared package constants:
  - BRAM_RD_LATENCY = 1
  - SKID_DEPTH = 2
  - OCC_WIDTH = 2 (occupancy width)
- One sub-module, `stream_buf2`: 2-entry in-order buffer with push/pop/clear, and outputs head data, count and valid.
- The top level holds the credit logic, pend/pend_discard and rd_count.

Test Plan:
1. Hold rst_n=0 with fifo_empty=0 -> fifo_re=0, m_valid=0, busy=0, rd_count=0. Release reset -> fifo_re=1 in the first cycle.
2. FIFO holds 0x11,0x22,0x33 and m_ready=1 -> fifo_re high for 3 consecutive cycles. m_data is 0x11,0x22,0x33 on 3 consecutive cycles, first beat 2 cycles after the first fifo_re. Then rd_count=3 and busy=0.
3. FIFO holds 5 words and m_ready=0 -> exactly 2 fifo_re pulses, m_valid=1 with m_data=0x11 held stable. Then m_ready=1 -> all 5 words delivered in order with no loss or duplicate, and rd_count=5.
4. m_ready toggling 1/0 every cycle with 8 words -> all 8 delivered in order, and the buffer never exceeds 2 entries.
5. 2 words buffered, 3 in the FIFO, flush pulsed for 4 cycles -> m_valid=0 the next cycle and the FIFO reaches empty. rd_count is unchanged and the late in-flight word is discarded. Afterwards write 0x44 -> exactly one beat with 0x44.
6. COUNT_WIDTH=4, 17 beats accepted -> rd_count=1. Asserting rst_n=0 mid-stream -> m_valid=0 and rd_count=0 immediately (asynchronous).
